// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like port between fetch (I) and load/store (D), routing responses via an in-order ID FIFO.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both masters request; otherwise D has fixed priority.
module sram_like_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

    state_e state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic push, pop, push_id, head, pick_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;
    assign pick_d = data_req & (~inst_req | ~last_q);
    always_ff @(posedge clk) begin
        if (reset) last_q <= 1'b0;
        else if (push) last_q <= push_id;
    end
`else
    assign pick_d = data_req;
`endif

    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
        mem_wr = 1'b0;
        mem_size = '0;
        mem_wstrb = '0;
        mem_addr = '0;
        mem_wdata = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        push = 1'b0;
        push_id = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q < MAX_C && (data_req | inst_req)) state_d = pick_d ? GNT_D : GNT_I;
            end
            GNT_I: begin
                mem_req = inst_req;
                mem_wr = inst_wr;
                mem_size = inst_size;
                mem_wstrb = inst_wstrb;
                mem_addr = inst_addr;
                mem_wdata = inst_wdata;
                inst_addr_ok = inst_req & mem_addr_ok;
                push = inst_addr_ok;
                if (!inst_req || mem_addr_ok) state_d = IDLE;
            end
            GNT_D: begin
                mem_req = data_req;
                mem_wr = data_wr;
                mem_size = data_size;
                mem_wstrb = data_wstrb;
                mem_addr = data_addr;
                mem_wdata = data_wdata;
                data_addr_ok = data_req & mem_addr_ok;
                push = data_addr_ok;
                push_id = 1'b1;
                if (!data_req || mem_addr_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses always belong to the FIFO head, never to a same-cycle push.
    assign head = id_q[rptr_q];
    assign pop = mem_data_ok & |count_q;
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    always_comb begin
        id_d = id_q;
        if (push) id_d[wptr_q] = push_id;
        wptr_d = push ? (wptr_q == PTR_LAST ? '0 : wptr_q + PW'(1)) : wptr_q;
        rptr_d = pop ? (rptr_q == PTR_LAST ? '0 : rptr_q + PW'(1)) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            id_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            id_q <= id_d;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed scenario tests for sram_like_arbiter (MAX_OUTSTANDING=2).
module tb_sram_like_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'b10; inst_wstrb = 4'hF; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'b10; data_wstrb = 4'h0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        inst_req = 1; inst_addr = 32'hFFFF_0000; data_wdata = 32'h1234_5678;
        do_reset();
        #1;
        tests++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++; $display("FAIL reset_idle_outputs: req=%b addr=%h wdata=%h, want 0/0/0", mem_req, mem_addr, mem_wdata);
        end
        tests++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            fails++; $display("FAIL reset_handshakes: %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
        end
        inst_req = 0;
        step();
    endtask

    task automatic test_single_read();
        inst_req = 1; inst_addr = 32'h1C00_0000; inst_wr = 0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rd_req_latency0: mem_req=%b want 0", mem_req); end
        step();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0000 || mem_wr !== 1'b0) begin
            fails++; $display("FAIL rd_grant: req=%b addr=%h wr=%b want 1/1c000000/0", mem_req, mem_addr, mem_wr);
        end
        mem_addr_ok = 1;
        #1;
        tests++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            fails++; $display("FAIL rd_addr_ok: i=%b d=%b want 1/0", inst_addr_ok, data_addr_ok);
        end
        step();
        inst_req = 0; mem_addr_ok = 0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rd_back_idle: mem_req=%b want 0", mem_req); end
        step();
        step();
        mem_data_ok = 1; mem_rdata = 32'h02C0_0000;
        #1;
        tests++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h02C0_0000) begin
            fails++; $display("FAIL rd_resp: i=%b d=%b rdata=%h want 1/0/02c00000", inst_data_ok, data_data_ok, inst_rdata);
        end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_simultaneous();
        inst_req = 1; inst_addr = 32'h1C00_0004;
        data_req = 1; data_addr = 32'h10; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'h0000_BEEF;
        step();
        tests++;
        if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h10 || mem_wdata !== 32'hBEEF) begin
            fails++; $display("FAIL sim_gnt_d: req=%b wr=%b strb=%b addr=%h wdata=%h", mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata);
        end
        mem_addr_ok = 1;
        #1;
        tests++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            fails++; $display("FAIL sim_d_addr_ok: d=%b i=%b want 1/0", data_addr_ok, inst_addr_ok);
        end
        step();
        data_req = 0; mem_addr_ok = 0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL sim_idle_between: mem_req=%b want 0", mem_req); end
        step();
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1C00_0004 || mem_wr !== 1'b0) begin
            fails++; $display("FAIL sim_gnt_i: req=%b addr=%h wr=%b want 1/1c000004/0", mem_req, mem_addr, mem_wr);
        end
        mem_addr_ok = 1;
        #1;
        tests++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            fails++; $display("FAIL sim_i_addr_ok: i=%b d=%b want 1/0", inst_addr_ok, data_addr_ok);
        end
        step();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_0001;
        #1;
        tests++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hAAAA_0001) begin
            fails++; $display("FAIL sim_resp_d: d=%b i=%b rdata=%h want 1/0/aaaa0001", data_data_ok, inst_data_ok, data_rdata);
        end
        step();
        mem_rdata = 32'hAAAA_0002;
        #1;
        tests++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            fails++; $display("FAIL sim_resp_i: i=%b d=%b want 1/0", inst_data_ok, data_data_ok);
        end
        step();
        mem_data_ok = 0; data_wr = 0; data_wstrb = 0;
    endtask

    task automatic test_fifo_full();
        inst_req = 1; inst_addr = 32'h1C00_0008;
        for (int k = 0; k < 2; k++) begin
            step();
            mem_addr_ok = 1;
            step();
            mem_addr_ok = 0;
        end
        step();
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL full_block: mem_req=%b want 0", mem_req); end
        mem_data_ok = 1;
        #1;
        tests++;
        if (inst_data_ok !== 1'b1) begin fails++; $display("FAIL full_pop: inst_data_ok=%b want 1", inst_data_ok); end
        step();
        mem_data_ok = 0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL full_same_cycle_pop: mem_req=%b want 0", mem_req); end
        step();
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL full_resume: mem_req=%b want 1", mem_req); end
        mem_addr_ok = 1;
        step();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        step();
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_coincident();
        inst_req = 1;
        step();
        mem_addr_ok = 1;
        step();
        inst_req = 0; mem_addr_ok = 0; data_req = 1;
        step();
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        tests++;
        if (inst_data_ok !== 1'b1 || data_addr_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            fails++; $display("FAIL coin_pulses: i_data=%b d_addr=%b d_data=%b want 1/1/0", inst_data_ok, data_addr_ok, data_data_ok);
        end
        step();
        data_req = 0; mem_addr_ok = 0;
        #1;
        tests++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0) begin
            fails++; $display("FAIL coin_count_kept: d=%b i=%b want 1/0", data_data_ok, inst_data_ok);
        end
        step();
        #1;
        tests++;
        if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            fails++; $display("FAIL coin_drained: d=%b i=%b want 0/0", data_data_ok, inst_data_ok);
        end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_stray_reset();
        mem_data_ok = 1;
        #1;
        tests++;
        if (inst_data_ok !== 1'b0 || data_data_ok !== 1'b0) begin
            fails++; $display("FAIL stray_ignored: i=%b d=%b want 0/0", inst_data_ok, data_data_ok);
        end
        step();
        mem_data_ok = 0; inst_req = 1;
        step();
        inst_req = 0;
        step();
        mem_data_ok = 1;
        #1;
        tests++;
        if (inst_data_ok !== 1'b0) begin fails++; $display("FAIL drop_no_push: inst_data_ok=%b want 0", inst_data_ok); end
        step();
        mem_data_ok = 0; data_req = 1;
        step();
        mem_addr_ok = 1;
        step();
        mem_addr_ok = 0;
        step();
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_pre_gnt_d: mem_req=%b want 1", mem_req); end
        reset = 1;
        step();
        reset = 0; data_req = 0;
        #1;
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_mid_grant: mem_req=%b want 0", mem_req); end
        mem_data_ok = 1;
        #1;
        tests++;
        if (data_data_ok !== 1'b0 || inst_data_ok !== 1'b0) begin
            fails++; $display("FAIL rst_count_cleared: d=%b i=%b want 0/0", data_data_ok, inst_data_ok);
        end
        step();
        mem_data_ok = 0;
    endtask

    task automatic test_priority();
        logic [3:0] exp_d;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        idle_inputs();
        do_reset();
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            tests++;
            if (data_addr_ok !== exp_d[k] || inst_addr_ok !== !exp_d[k]) begin
                fails++; $display("FAIL prio_grant%0d: d=%b i=%b want %b/%b", k, data_addr_ok, inst_addr_ok, exp_d[k], !exp_d[k]);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_simultaneous();
        test_fifo_full();
        test_coincident();
        test_stray_reset();
        test_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
